hazard_stall_controller: RTL
============================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core; sits beside the EX-stage operand forwarding logic.
- Resolves the hazards that forwarding cannot cover:
  - load-use dependencies, resolved with a one-cycle bubble;
  - multi-cycle MUL/DIV occupancy of EX, resolved with an FSM-timed freeze;
  - taken-branch redirects, resolved with an IF/ID flush and an ID/EX bubble.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MULDIV_CYCLES, 4, cycles the MUL/DIV unit needs; EX frozen this many cycles (legal range 2..255)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous active-high reset
rs1_id  input  5  rs1 of instruction in ID
rs2_id  input  5  rs2 of instruction in ID
rs1_used_id  input  1  ID instruction reads rs1
rs2_used_id  input  1  ID instruction reads rs2
rd_ex  input  5  rd of instruction in EX
mem_read_ex  input  1  EX instruction is a load
muldiv_ex  input  1  EX instruction is MUL/DIV
branch_taken_ex  input  1  EX resolved a taken branch/jump
stall_cnt_clr  input  1  clear stall counter
stall_if  output  1  hold PC
stall_id  output  1  hold IF/ID register
stall_ex  output  1  hold ID/EX register and EX operands
bubble_ex  output  1  load NOP into ID/EX
flush_id  output  1  clear IF/ID to NOP
bubble_mem  output  1  load NOP into EX/MEM while EX frozen
muldiv_done  output  1  MUL/DIV result valid this cycle
muldiv_busy  output  1  FSM in BUSY
stall_cycles  output  CNT_W  count of cycles with stall_if=1

Behaviour:
- All outputs are 0 during any cycle with rst=1. Reset sets state IDLE, internal cnt=0 and stall_cycles=0.
- FSM states: IDLE, BUSY, DONE. 8-bit down-counter cnt.
  - IDLE and muldiv_ex=1: freeze this cycle; cnt<=MULDIV_CYCLES-2; go to BUSY.
  - BUSY: freeze; muldiv_busy=1; cnt<=cnt-1; when cnt==0, go to DONE.
  - DONE: no freeze; muldiv_done=1; the MUL/DIV instruction advances at the end of this cycle; always go to IDLE. muldiv_ex is ignored in DONE (it is the same instruction).
  - Result: exactly MULDIV_CYCLES frozen cycles per MUL/DIV, plus the DONE cycle.
  - A back-to-back MUL/DIV arriving in EX the cycle after DONE restarts from IDLE normally.
- Freeze means stall_if=stall_id=stall_ex=1 and bubble_mem=1; bubble_ex=0 and flush_id=0.
- load_use = mem_read_ex & (rd_ex!=0) & ((rs1_used_id & rd_ex==rs1_id) | (rs2_used_id & rd_ex==rs2_id)).
- When not freezing and not branching, load_use=1 gives stall_if=stall_id=1 and bubble_ex=1 for exactly one cycle; stall_ex=0. The load advances and is then forwarded.
- branch_taken_ex=1 when not freezing gives flush_id=1 and bubble_ex=1; stall_if=stall_id=0 so the redirect PC loads.
- Priority, highest first: rst, freeze, branch, load_use.
  - Branch suppresses load_use, because the ID instruction is killed.
  - branch_taken_ex and load_use are ignored during BUSY and the IDLE start cycle.
- muldiv_ex together with branch_taken_ex is illegal (same slot); the freeze wins.
- stall_cycles increments by 1 each cycle stall_if=1 and saturates at all-ones without wrapping.
- stall_cnt_clr has priority over increment: the counter becomes 0 next cycle.
- Reset asserted mid-BUSY: state IDLE next cycle; no muldiv_done pulse is emitted.
- All outputs except stall_cycles and muldiv_busy are combinational from state and inputs. There is no output-to-input combinational loop.

Test Plan:
- Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 for one cycle -> stall_if=stall_id=bubble_ex=1 that cycle only, stall_ex=0; stall_cycles increments 0->1.
- x0 and unused operands: rd_ex=0 with rs1_id=0; separately rd_ex=7, rs2_id=7, rs2_used_id=0 -> all stall and flush outputs 0.
- MUL/DIV with MULDIV_CYCLES=4: muldiv_ex=1 held -> stall_ex=1 for cycles 0..3, muldiv_busy=1 for cycles 1..3, muldiv_done=1 in cycle 4 with stalls 0, IDLE in cycle 5; stall_cycles=4.
- Branch with load-use: branch_taken_ex=1 together with a load_use condition -> flush_id=bubble_ex=1, stall_if=0; next cycle all 0.
- Reset mid-BUSY: rst=1 in cycle 2 of a MUL/DIV -> all outputs 0; after release with muldiv_ex=0, no muldiv_done ever occurs and stall_cycles=0.
- Counter: CNT_W=3, 9 consecutive freeze cycles -> stall_cycles saturates at 7; stall_cnt_clr=1 during a stall -> 0 next cycle.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use, MUL/DIV and branch hazard sequencing with stall counter
module hazard_stall_controller #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             muldiv_ex,
  input  logic             branch_taken_ex,
  input  logic             stall_cnt_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             bubble_mem,
  output logic             muldiv_done,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  // The start cycle counts as the first frozen cycle, and BUSY exits after
  // seeing cnt==0, so BUSY lasts MULDIV_CYCLES-1 cycles.
  localparam logic [7:0] CNT_INIT = 8'(MULDIV_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       cnt;
  logic             busy_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic load_use;
  logic start;
  logic freeze;
  logic branch_act;
  logic load_stall;
  logic stall_front;

  // Hazard detection and priority resolution: freeze > branch > load-use.
  always_comb begin
    load_use    = 1'b0;
    start       = 1'b0;
    freeze      = 1'b0;
    branch_act  = 1'b0;
    load_stall  = 1'b0;
    stall_front = 1'b0;

    load_use = mem_read_ex && (rd_ex != 5'd0) &&
               ((rs1_used_id && (rd_ex == rs1_id)) ||
                (rs2_used_id && (rd_ex == rs2_id)));

    // muldiv_ex in DONE is the finishing instruction itself, so only IDLE starts.
    start  = (state == IDLE) && muldiv_ex;
    freeze = start || (state == BUSY);

    // A taken branch kills the ID instruction, so its load-use is moot.
    branch_act = !freeze && branch_taken_ex;
    load_stall = !freeze && !branch_taken_ex && load_use;

    stall_front = freeze || load_stall;
  end

  // Output drive; everything is forced low while reset is asserted.
  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    bubble_ex    = 1'b0;
    flush_id     = 1'b0;
    bubble_mem   = 1'b0;
    muldiv_done  = 1'b0;
    muldiv_busy  = 1'b0;
    stall_cycles = '0;
    if (!rst) begin
      stall_if     = stall_front;
      stall_id     = stall_front;
      stall_ex     = freeze;
      bubble_ex    = branch_act || load_stall;
      flush_id     = branch_act;
      bubble_mem   = freeze;
      muldiv_done  = (state == DONE);
      muldiv_busy  = busy_q;
      stall_cycles = stall_cnt_q;
    end
  end

  // MUL/DIV occupancy FSM with its 8-bit down-counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (muldiv_ex) begin
            state  <= BUSY;
            cnt    <= CNT_INIT;
            busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            state  <= DONE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnt    <= 8'd0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (stall_front && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
